// File: rtl/wb_dmem_slave.sv
// Wishbone-classic data-memory responder for the core's dwb_* port.
// Byte-lane writes, programmable wait states, registered ack/err and
// an error termination for addresses outside the mapped window.
module wb_dmem_slave #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
  localparam logic        NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0]  WS_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic [3:0]  sel_reg;
  logic        we_reg;
  logic        in_range_reg;

  logic          in_idle;
  logic          take;
  logic          commit;
  logic [31:0]   eff_adr;
  logic [31:0]   eff_dat;
  logic [31:0]   eff_off;
  logic [3:0]    eff_sel;
  logic          eff_we;
  logic          eff_in_range;
  logic [AW-1:0] eff_idx;
  logic [31:0]   rd_word;

  // Effective request: live bus inputs while idle (zero-wait commit happens
  // on the capture edge), captured copies once the request is in flight.
  always_comb begin
    in_idle      = (state_reg == ST_IDLE);
    take         = in_idle && wb_cyc_i && wb_stb_i;
    eff_adr      = in_idle ? wb_adr_i : adr_reg;
    eff_dat      = in_idle ? wb_dat_i : dat_reg;
    eff_sel      = in_idle ? wb_sel_i : sel_reg;
    eff_we       = in_idle ? wb_we_i  : we_reg;
    eff_off      = eff_adr - BASE_ADDR;
    eff_in_range = (eff_off < SPAN);
    eff_idx      = eff_off[AW+1:2];
    // Commit = the edge that enters RESP; the memory is touched only here.
    commit       = rst_n && ((take && NO_WAIT) ||
                             (state_reg == ST_WAIT && wb_cyc_i && cnt_reg == 4'd0));
  end

  // One byte-wide RAM per lane so each select bit maps to its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    // Lane write on commit of an in-range write with this lane selected
    always_ff @(posedge clk) begin
      if (commit && eff_we && eff_in_range && eff_sel[gi])
        mem[eff_idx] <= eff_dat[8*gi +: 8];
    end

    assign rd_word[8*gi +: 8] = mem[eff_idx];
  end

  // Request FSM with registered ack/err and read-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      adr_reg      <= 32'd0;
      dat_reg      <= 32'd0;
      sel_reg      <= 4'd0;
      we_reg       <= 1'b0;
      in_range_reg <= 1'b0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_dat_o     <= 32'd0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;

      if (commit && !eff_we)
        wb_dat_o <= eff_in_range ? rd_word : 32'd0;

      case (state_reg)
        ST_IDLE: begin
          if (take) begin
            adr_reg      <= wb_adr_i;
            dat_reg      <= wb_dat_i;
            sel_reg      <= wb_sel_i;
            we_reg       <= wb_we_i;
            in_range_reg <= eff_in_range;
            if (NO_WAIT) begin
              state_reg <= ST_RESP;
            end else begin
              cnt_reg   <= WS_LOAD;
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i)
            state_reg <= ST_IDLE;
          else if (cnt_reg == 4'd0)
            state_reg <= ST_RESP;
          else
            cnt_reg <= cnt_reg - 4'd1;
        end
        ST_RESP: begin
          wb_ack_o  <= in_range_reg;
          wb_err_o  <= !in_range_reg;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dmem_slave.sv
// Bench for wb_dmem_slave: two instances (zero-wait at base 0, three-wait
// at a non-zero base), a timeline/memory model checked every cycle, and
// directed transfers with literal expectations.
module tb_wb_dmem_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr [2];
  logic [31:0] wdat [2];
  logic        we [2];
  logic [3:0]  sel [2];
  logic        cyc [2];
  logic        stb [2];
  logic [31:0] rdat [2];
  logic        ack [2];
  logic        err [2];

  wb_dmem_slave #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]));

  wb_dmem_slave #(.DEPTH_WORDS(64), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_ws [2]    = '{0, 3};
  logic [31:0] m_base [2]  = '{32'h0000_0000, 32'h1000_0000};
  int unsigned m_depth [2] = '{256, 64};

  logic [7:0]  mm [2][256][4];
  bit          mv [2][256][4];
  int          mode [2];         // 0 free, 1 waiting for commit, 2 terminating next edge
  int          commit_t [2];
  int          t = 0;
  logic [31:0] c_adr [2];
  logic [31:0] c_dat [2];
  logic [3:0]  c_sel [2];
  logic        c_we [2];
  bit          c_inr [2];
  logic        e_ack [2];
  logic        e_err [2];
  logic [31:0] e_dat [2];
  bit          e_ok [2];

  function automatic bit m_in_range(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - m_base[d];
    return off < 32'(m_depth[d] * 4);
  endfunction

  task automatic m_commit(input int d);
    logic [31:0] off;
    int idx;
    off = c_adr[d] - m_base[d];
    idx = int'(off >> 2);
    if (c_inr[d]) begin
      if (c_we[d]) begin
        for (int b = 0; b < 4; b++)
          if (c_sel[d][b]) begin
            mm[d][idx][b] = c_dat[d][8*b +: 8];
            mv[d][idx][b] = 1'b1;
          end
      end else begin
        e_dat[d] = {mm[d][idx][3], mm[d][idx][2], mm[d][idx][1], mm[d][idx][0]};
        e_ok[d]  = mv[d][idx][0] && mv[d][idx][1] && mv[d][idx][2] && mv[d][idx][3];
      end
    end else if (!c_we[d]) begin
      e_dat[d] = 32'd0;
      e_ok[d]  = 1'b1;
    end
    mode[d] = 2;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0; e_ack[d] = 0; e_err[d] = 0; e_dat[d] = 0; e_ok[d] = 1;
      for (int i = 0; i < 256; i++)
        for (int b = 0; b < 4; b++) mv[d][i][b] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          mode[d] = 0; e_ack[d] = 0; e_err[d] = 0; e_dat[d] = 0; e_ok[d] = 1;
        end
      end else begin
        t++;
        for (int d = 0; d < 2; d++) begin
          e_ack[d] = 0;
          e_err[d] = 0;
          case (mode[d])
            2: begin
              if (c_inr[d]) e_ack[d] = 1; else e_err[d] = 1;
              mode[d] = 0;
            end
            1: begin
              if (!cyc[d]) mode[d] = 0;
              else if (t == commit_t[d]) m_commit(d);
            end
            default: begin
              if (cyc[d] && stb[d]) begin
                c_adr[d] = adr[d]; c_dat[d] = wdat[d]; c_sel[d] = sel[d]; c_we[d] = we[d];
                c_inr[d] = m_in_range(d, adr[d]);
                commit_t[d] = t + int'(m_ws[d]);
                if (m_ws[d] == 0) m_commit(d);
                else mode[d] = 1;
              end
            end
          endcase
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("dut%0d_ack_t%0d", d, t), 32'(ack[d]), 32'(e_ack[d]));
          chk($sformatf("dut%0d_err_t%0d", d, t), 32'(err[d]), 32'(e_err[d]));
          if ((e_ack[d] || e_err[d]) && e_ok[d])
            chk($sformatf("dut%0d_dat_t%0d", d, t), rdat[d], e_dat[d]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd, input logic w,
                      input logic [3:0] s, output logic got_ack, output logic got_err,
                      output int lat);
    @(posedge clk); #1;
    adr[d] = a; wdat[d] = wd; we[d] = w; sel[d] = s; cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);  // capture edge
    lat = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    while (lat < 40 && !got_ack && !got_err) begin
      @(posedge clk);
      lat++;
      #1;
      got_ack = ack[d];
      got_err = err[d];
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    $display("xfer dut%0d adr=%h we=%0d sel=%b wdat=%h -> ack=%0d err=%0d lat=%0d rdat=%h",
             d, a, w, s, wd, got_ack, got_err, lat, rdat[d]);
  endtask

  localparam logic [31:0] B3 = 32'h1000_0000;

  initial begin
    logic ga, ge;
    int lat;
    int acks;
    bit prev_ack, dbl;

    for (int d = 0; d < 2; d++) begin
      adr[d] = 0; wdat[d] = 0; we[d] = 0; sel[d] = 0; cyc[d] = 0; stb[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ack%0d", d), 32'(ack[d]), 32'd0);
      chk($sformatf("reset_err%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("reset_dat%0d", d), rdat[d], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // zero-wait write then read
    xfer(0, 32'h10, 32'hDEAD_BEEF, 1, 4'hF, ga, ge, lat);
    chk("t1_wr_ack", 32'(ga), 32'd1);
    chk("t1_wr_lat", lat, 32'd1);
    xfer(0, 32'h10, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t1_rd_lat", lat, 32'd1);
    chk("t1_rd_dat", rdat[0], 32'hDEAD_BEEF);

    // byte lanes, including an empty select
    xfer(0, 32'h20, 32'h1122_3344, 1, 4'hF, ga, ge, lat);
    xfer(0, 32'h20, 32'hAABB_CCDD, 1, 4'b0101, ga, ge, lat);
    xfer(0, 32'h20, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t2_lanes", rdat[0], 32'h11BB_33DD);
    xfer(0, 32'h20, 32'hFFFF_FFFF, 1, 4'b0000, ga, ge, lat);
    chk("t2_sel0_ack", 32'(ga), 32'd1);
    xfer(0, 32'h20, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t2_sel0_dat", rdat[0], 32'h11BB_33DD);

    // range boundaries on the zero-wait instance
    xfer(0, 32'h0, 32'h0102_0304, 1, 4'hF, ga, ge, lat);
    xfer(0, 32'h3FC, 32'h5555_AAAA, 1, 4'hF, ga, ge, lat);
    chk("t4_last_ack", 32'(ga), 32'd1);
    xfer(0, 32'h400, 32'hFFFF_FFFF, 1, 4'hF, ga, ge, lat);
    chk("t4_oor_wr_err", 32'(ge), 32'd1);
    chk("t4_oor_wr_noack", 32'(ga), 32'd0);
    xfer(0, 32'h0, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t4_word0", rdat[0], 32'h0102_0304);
    xfer(0, 32'h3FC, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t4_last_dat", rdat[0], 32'h5555_AAAA);
    xfer(0, 32'h400, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t4_oor_rd_err", 32'(ge), 32'd1);
    chk("t4_oor_rd_dat", rdat[0], 32'd0);

    // three wait states at a non-zero base
    xfer(1, B3 + 32'h10, 32'h5A5A_A5A5, 1, 4'hF, ga, ge, lat);
    chk("t3_wr_lat", lat, 32'd4);
    xfer(1, B3 + 32'h10, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t3_rd_lat", lat, 32'd4);
    chk("t3_rd_ack", 32'(ga), 32'd1);
    chk("t3_rd_dat", rdat[1], 32'h5A5A_A5A5);
    xfer(1, B3 - 32'h4, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t3_below_err", 32'(ge), 32'd1);
    xfer(1, B3 + 32'h100, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t3_above_err", 32'(ge), 32'd1);
    chk("t3_above_lat", lat, 32'd4);

    // held strobe: terminations every other cycle
    @(posedge clk); #1;
    adr[0] = 32'h10; we[0] = 0; sel[0] = 4'hF; cyc[0] = 1; stb[0] = 1;
    acks = 0; prev_ack = 0; dbl = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ack[0] && prev_ack) dbl = 1;
      if (ack[0]) acks++;
      prev_ack = ack[0];
      $display("held cycle ack=%0d rdat=%h", ack[0], rdat[0]);
    end
    cyc[0] = 0; stb[0] = 0;
    chk("t6_ack_count", acks, 32'd5);
    chk("t6_no_double", 32'(dbl), 32'd0);

    // abort during wait
    xfer(1, B3 + 32'h30, 32'hCAFE_F00D, 1, 4'hF, ga, ge, lat);
    xfer(1, B3 + 32'h30, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t5_pre_dat", rdat[1], 32'hCAFE_F00D);
    @(posedge clk); #1;
    adr[1] = B3 + 32'h30; wdat[1] = 32'h1234_5678; we[1] = 1; sel[1] = 4'hF; cyc[1] = 1; stb[1] = 1;
    repeat (2) @(posedge clk);
    #1;
    cyc[1] = 0; stb[1] = 0; we[1] = 0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) acks++;
    end
    $display("abort dut1 terminations=%0d", acks);
    chk("t5_abort_noterm", acks, 32'd0);
    xfer(1, B3 + 32'h30, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t5_abort_mem", rdat[1], 32'hCAFE_F00D);

    // reset in the middle of a wait
    @(posedge clk); #1;
    adr[1] = B3 + 32'h30; wdat[1] = 32'h0BAD_F00D; we[1] = 1; sel[1] = 4'hF; cyc[1] = 1; stb[1] = 1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ack", 32'(ack[1]), 32'd0);
    chk("t5_rst_err", 32'(err[1]), 32'd0);
    chk("t5_rst_dat", rdat[1], 32'd0);
    $display("reset mid-wait dut1 ack=%0d err=%0d rdat=%h", ack[1], err[1], rdat[1]);
    cyc[1] = 0; stb[1] = 0; we[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, B3 + 32'h30, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t5_rst_mem", rdat[1], 32'hCAFE_F00D);
    xfer(0, 32'h10, 32'h0, 0, 4'hF, ga, ge, lat);
    chk("t5_rst_mem0", rdat[0], 32'hDEAD_BEEF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
